// File: rtl/div_iter_radix_if.sv
// -----------------------------------------------------------------------------
// div_iter_radix_if
// Execute-stage handshake bundle for the iterative divider.
//   en         request, held with stable operands until out_valid && out_ready
//   in1, in2   dividend / divisor
//   div_word   32-bit operation, result sign-extended
//   op         00 DIV, 01 DIVU, 10 REM, 11 REMU
//   out        registered result
//   out_valid  result available
//   out_ready  consumer accepts the result
//   busy       divider is not idle
// Modports: master (execute stage driving requests), slave (the divider).
// -----------------------------------------------------------------------------
interface div_iter_radix_if #(
    parameter int XLEN = 64
);
    logic            en;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic            div_word;
    logic [1:0]      op;
    logic [XLEN-1:0] out;
    logic            out_valid;
    logic            out_ready;
    logic            busy;

    modport master (
        output en, in1, in2, div_word, op, out_ready,
        input  out, out_valid, busy
    );

    modport slave (
        input  en, in1, in2, div_word, op, out_ready,
        output out, out_valid, busy
    );
endinterface

// File: rtl/div_iter_radix.sv
// -----------------------------------------------------------------------------
// div_iter_radix
// Iterative restoring divider for RISC-V DIV/DIVU/REM/REMU and their W forms.
// Retires BITS_PER_CYCLE quotient bits per cycle; with EARLY_OUT the iteration
// count covers only the significant bits of |dividend|. Divide-by-zero,
// signed overflow and zero dividend resolve in one cycle.
// Ports:
//   clock   clock
//   reset   synchronous, active-high
//   flush   abort in-flight operation (same effect as reset)
//   io      div_iter_radix_if.slave handshake (en/operands/op in, out/out_valid/busy out)
// -----------------------------------------------------------------------------
module div_iter_radix #(
    parameter int XLEN           = 64,
    parameter int BITS_PER_CYCLE = 1,
    parameter int EARLY_OUT      = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    div_iter_radix_if.slave   io
);
    localparam int B     = BITS_PER_CYCLE;
    localparam int LOG2B = $clog2(BITS_PER_CYCLE);
    localparam int CW    = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_FULL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    function automatic logic [XLEN-1:0] neg2c(input logic [XLEN-1:0] x);
        return '0 - x;
    endfunction

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        logic signed [31:0] s;
        s = x;
        return XLEN'(s);
    endfunction

    function automatic logic [XLEN-1:0] word_ext(input logic [XLEN-1:0] x, input logic word);
        return word ? sext32(x[31:0]) : x;
    endfunction

    state_t          state, state_nxt;
    logic            accept;

    logic [XLEN:0]   rem_q;
    logic [XLEN-1:0] quo_q, dsr_q, out_q;
    logic [CW-1:0]   cnt_q;
    logic            q_neg_q, r_neg_q, is_rem_q, word_q;

    // Operand decode, special cases and iteration count at the accept edge
    logic            is_signed, is_rem, a_neg, b_neg;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, spec_res;
    logic            spec_hit;
    logic [CW-1:0]   len, n_iter, shamt;

    always_comb begin
        is_signed = ~io.op[0];
        is_rem    = io.op[1];
        if (io.div_word) begin
            a_ext = is_signed ? sext32(io.in1[31:0]) : XLEN'(io.in1[31:0]);
            b_ext = is_signed ? sext32(io.in2[31:0]) : XLEN'(io.in2[31:0]);
        end else begin
            a_ext = io.in1;
            b_ext = io.in2;
        end
        a_neg   = is_signed & a_ext[XLEN-1];
        b_neg   = is_signed & b_ext[XLEN-1];
        a_mag   = a_neg ? neg2c(a_ext) : a_ext;
        b_mag   = b_neg ? neg2c(b_ext) : b_ext;
        min_val = io.div_word ? sext32(32'h8000_0000) : MIN_FULL;

        spec_hit = 1'b1;
        spec_res = '0;
        if (b_ext == '0)
            spec_res = is_rem ? a_ext : '1;
        else if (is_signed && (a_ext == min_val) && (b_ext == '1))
            spec_res = is_rem ? '0 : a_ext;
        else if (a_ext == '0)
            spec_res = '0;
        else
            spec_hit = 1'b0;
        spec_res = word_ext(spec_res, io.div_word);

        len = '0;
        for (int i = 0; i < XLEN; i++)
            if (a_mag[i]) len = CW'(i + 1);

        if (EARLY_OUT != 0)
            n_iter = CW'((len + CW'(B - 1)) >> LOG2B);
        else
            n_iter = io.div_word ? CW'(32 / B) : CW'(XLEN / B);
        // Align the significant dividend bits to the top of the shift register
        shamt = CW'(XLEN) - CW'(n_iter << LOG2B);
    end

    assign accept = (state == IDLE) && io.en && !flush && !reset;

    // CALC: BITS_PER_CYCLE restoring steps, then sign fix-up of the result
    logic [XLEN:0]   rem_nxt;
    logic [XLEN-1:0] quo_nxt, q_fin, r_fin, calc_res;

    always_comb begin
        rem_nxt = rem_q;
        quo_nxt = quo_q;
        for (int k = 0; k < B; k++) begin
            rem_nxt = {rem_nxt[XLEN-1:0], quo_nxt[XLEN-1]};
            quo_nxt = {quo_nxt[XLEN-2:0], 1'b0};
            if (rem_nxt >= {1'b0, dsr_q}) begin
                rem_nxt    = rem_nxt - {1'b0, dsr_q};
                quo_nxt[0] = 1'b1;
            end
        end
        q_fin    = q_neg_q ? neg2c(quo_nxt) : quo_nxt;
        r_fin    = r_neg_q ? neg2c(rem_nxt[XLEN-1:0]) : rem_nxt[XLEN-1:0];
        calc_res = word_ext(is_rem_q ? r_fin : q_fin, word_q);
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            quo_q    <= a_mag << shamt;
            rem_q    <= '0;
            dsr_q    <= b_mag;
            cnt_q    <= n_iter;
            q_neg_q  <= is_signed & (a_neg ^ b_neg);
            r_neg_q  <= a_neg;
            is_rem_q <= is_rem;
            word_q   <= io.div_word;
        end else if (state == CALC) begin
            quo_q <= quo_nxt;
            rem_q <= rem_nxt;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush)
            out_q <= '0;
        else if (accept && spec_hit)
            out_q <= spec_res;
        else if ((state == CALC) && (cnt_q == CW'(1)))
            out_q <= calc_res;
    end

    // Control FSM
    always_ff @(posedge clock) begin
        if (reset || flush)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        io.out_valid = 1'b0;
        io.busy      = 1'b0;
        case (state)
            IDLE: if (accept) state_nxt = spec_hit ? DONE : CALC;
            CALC: begin
                io.busy = 1'b1;
                if (cnt_q == CW'(1)) state_nxt = DONE;
            end
            DONE: begin
                io.busy      = 1'b1;
                io.out_valid = 1'b1;
                if (io.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign io.out = out_q;
endmodule
